// File: rtl/led_display_regs.sv
// led_display_regs: VALUE/CTRL/STATUS register window feeding the 8-digit seven-segment driver.
// Define LED_DISPLAY_BCD_EN to build the sequential double-dabble BCD conversion path.
module led_display_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] data,
    output logic        enable_n
);
    localparam int unsigned DW = 32;
    localparam int unsigned NB = 4;

    logic          in_window;
    logic [1:0]    reg_sel;
    logic          wr_value;
    logic          wr_ctrl;
    logic [DW-1:0] value_q;
    logic [DW-1:0] value_n;
    logic          en_q;
    logic          dec_q;
    logic          frz_q;
    logic          en_n;
    logic          dec_n;
    logic          frz_n;
    logic          abort;
    logic          release_frz;
    logic          busy_d;
    logic          done_fire;
    logic          ovf_q;
    logic [DW-1:0] result_d;
    logic [DW-1:0] data_d;
    logic [DW-1:0] rd_d;
    logic          unused_addr;

    assign in_window   = addr[31:4] == BASE_ADDR[31:4];
    assign reg_sel     = addr[3:2];
    assign unused_addr = ^addr[1:0];
    assign wr_value    = we && in_window && (reg_sel == 2'd0);
    assign wr_ctrl     = we && in_window && (reg_sel == 2'd1);

    // Byte-masked merge of the incoming VALUE store
    always_comb begin
        value_n = value_q;
        for (int i = 0; i < int'(NB); i++) begin
            if (wr_value && wmask[i]) value_n[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_comb begin
        en_n  = en_q;
        dec_n = dec_q;
        frz_n = frz_q;
        if (wr_ctrl && wmask[0]) begin
            en_n  = wdata[0];
`ifdef LED_DISPLAY_BCD_EN
            dec_n = wdata[1];
`else
            dec_n = 1'b0;
`endif
            frz_n = wdata[2];
        end
    end

    assign abort       = wr_ctrl && dec_q && !dec_n;
    assign release_frz = frz_q && !frz_n;

`ifdef LED_DISPLAY_BCD_EN
    localparam int unsigned SW     = 64;
    localparam int unsigned CW     = 6;
    localparam int unsigned STEPS  = 32;
    localparam int unsigned DIGITS = 8;
    localparam logic [DW-1:0] DEC_MAX  = 32'd99_999_999;
    localparam logic [DW-1:0] OVF_WORD = 32'h9999_9999;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] shift_q, shift_d;
    logic [CW-1:0] step_q, step_d;
    logic          ovf_d;
    logic [DW-1:0] result_q;
    logic          trigger;

    assign trigger = (wr_value && dec_q) || (wr_ctrl && !dec_q && dec_n);

    function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (t[DW + 4*d +: 4] >= 4'd5) t[DW + 4*d +: 4] = t[DW + 4*d +: 4] + 4'd3;
        end
        return {t[SW-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        step_d    = step_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        done_fire = 1'b0;
        case (state_q)
            CONV: begin
                shift_d = dabble_step(shift_q);
                step_d  = step_q + CW'(1);
                if (step_q == CW'(STEPS - 1)) state_d = DONE;
            end
            DONE: begin
                result_d  = ovf_q ? OVF_WORD : shift_q[SW-1:DW];
                done_fire = 1'b1;
                state_d   = IDLE;
            end
            default: ;
        endcase
        // Abort or restart discards whatever was in flight, including a DONE this edge
        if (abort || trigger) begin
            state_d   = IDLE;
            result_d  = result_q;
            done_fire = 1'b0;
        end
        if (trigger) begin
            state_d = CONV;
            shift_d = {DW'(0), value_n};
            step_d  = '0;
            ovf_d   = value_n > DEC_MAX;
        end
    end

    assign busy_d = state_d != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            step_q   <= '0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            step_q   <= step_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end
`else
    assign busy_d    = 1'b0;
    assign done_fire = 1'b0;
    assign ovf_q     = 1'b0;
    assign result_d  = '0;
`endif

    // Display word: held while frozen, otherwise reloaded on release, abort, hex store or DONE
    always_comb begin
        data_d = data;
        if (!frz_n) begin
            if (release_frz || abort || (wr_value && !dec_q)) begin
                data_d = dec_n ? result_d : value_n;
            end else if (done_fire) begin
                data_d = result_d;
            end
        end
    end

    always_comb begin
        rd_d = '0;
        if (in_window) begin
            case (reg_sel)
                2'd0:    rd_d = value_q;
                2'd1:    rd_d = {29'd0, frz_q, dec_q, en_q};
                2'd2:    rd_d = {30'd0, ovf_q, busy};
                default: rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q  <= '0;
            en_q     <= 1'b0;
            dec_q    <= 1'b0;
            frz_q    <= 1'b0;
            data     <= '0;
            enable_n <= 1'b1;
            busy     <= 1'b0;
            rdata    <= '0;
        end else begin
            value_q  <= value_n;
            en_q     <= en_n;
            dec_q    <= dec_n;
            frz_q    <= frz_n;
            data     <= data_d;
            enable_n <= ~en_n;
            busy     <= busy_d;
            if (re) rdata <= rd_d;
        end
    end
endmodule

// File: tb/tb_led_display_regs.sv
// tb_led_display_regs: directed bench with a cycle-level reference model checked every cycle.
// Follows whichever build of led_display_regs is compiled (LED_DISPLAY_BCD_EN or plain hex).
module tb_led_display_regs;
`ifdef LED_DISPLAY_BCD_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int CONV_CYCLES = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] data;
    logic        enable_n;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    led_display_regs #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wmask(wmask), .wdata(wdata),
        .re(re), .rdata(rdata), .busy(busy), .data(data), .enable_n(enable_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [31:0] dec_val, input logic [31:0] hex_val);
        return BCD_EN ? dec_val : hex_val;
    endfunction

    // Decimal digits by division; saturates past eight digits
    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] x;
        r = '0;
        x = v;
        if (v > 32'd99_999_999) return 32'h9999_9999;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    logic [31:0] m_value = '0, m_data = '0, m_rdata = '0, m_result = '0, m_pend = '0;
    bit m_en = 0, m_dec = 0, m_frz = 0, m_ovf = 0;
    int m_cnt = 0;

    // Reference model: pending conversion is a countdown to the cycle its result lands
    always @(posedge clk) begin : model
        logic [31:0] rd, nv;
        bit hit, wv, wc, ndec, nfrz, trig, abrt, done, rel;
        if (rst) begin
            m_value = '0; m_data = '0; m_rdata = '0; m_result = '0; m_pend = '0;
            m_en = 0; m_dec = 0; m_frz = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            hit = addr[31:4] == BASE[31:4];
            rd = '0;
            if (hit && addr[3:2] == 2'd0) rd = m_value;
            if (hit && addr[3:2] == 2'd1) rd = {29'd0, m_frz, m_dec, m_en};
            if (hit && addr[3:2] == 2'd2) rd = {30'd0, m_ovf, m_cnt > 0};
            if (re) m_rdata = rd;
            wv = we && hit && addr[3:2] == 2'd0;
            wc = we && hit && addr[3:2] == 2'd1;
            nv = m_value;
            for (int i = 0; i < 4; i++) if (wv && wmask[i]) nv[8*i +: 8] = wdata[8*i +: 8];
            ndec = m_dec;
            nfrz = m_frz;
            if (wc && wmask[0]) begin
                m_en = wdata[0];
                ndec = BCD_EN && wdata[1];
                nfrz = wdata[2];
            end
            trig = (wv && m_dec) || (!m_dec && ndec);
            abrt = m_dec && !ndec;
            done = (m_cnt == 1) && !trig && !abrt;
            if (done) m_result = m_pend;
            if (m_cnt > 0) m_cnt--;
            if (abrt) m_cnt = 0;
            if (trig) begin
                m_cnt = CONV_CYCLES;
                m_pend = to_bcd(nv);
                m_ovf = nv > 32'd99_999_999;
            end
            rel = m_frz && !nfrz;
            if (!nfrz) begin
                if (rel || abrt || (wv && !m_dec)) m_data = ndec ? m_result : nv;
                else if (done) m_data = m_result;
            end
            m_value = nv;
            m_dec = ndec;
            m_frz = nfrz;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("data", data, m_data);
            check("enable_n", 32'(enable_n), 32'(!m_en));
            check("busy", 32'(busy), 32'(m_cnt > 0));
            check("rdata", rdata, m_rdata);
        end
    end

    // All bus tasks start and end on a falling edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; wmask = m; we = 1'b1;
        @(negedge clk);
        we = 1'b0; wmask = '0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic bus_rw(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wmask = 4'hF; we = 1'b1; re = 1'b1;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wmask = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("rst_data", data, 32'h0);
        check("rst_enable_n", 32'(enable_n), 32'h1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(2);

        bus_write(BASE + 32'h4, 32'h1, 4'hF);
        bus_write(BASE, 32'hDEAD_BEEF, 4'hF);
        bus_write(BASE, 32'h0000_0012, 4'h1);
        check("hex_enable_n", 32'(enable_n), 32'h0);
        check("hex_bytewrite", data, 32'hDEAD_BE12);
        bus_read(BASE);
        check("hex_readback", rdata, 32'hDEAD_BE12);

        bus_write(BASE + 32'h4, 32'h3, 4'hF);
        bus_write(BASE, 32'd12_345_678, 4'hF);
        check("conv_busy_first", 32'(busy), pick(32'h1, 32'h0));
        idle(32);
        check("conv_busy_last", 32'(busy), pick(32'h1, 32'h0));
        check("conv_data_held", data, pick(32'hDEAD_BE12, 32'h00BC_614E));
        idle(1);
        check("conv_busy_done", 32'(busy), 32'h0);
        check("conv_12345678", data, pick(32'h1234_5678, 32'h00BC_614E));
        bus_read(BASE + 32'h8);
        check("status_clean", rdata, 32'h0);

        bus_write(BASE, 32'd100_000_000, 4'hF);
        idle(CONV_CYCLES);
        check("ovf_data", data, pick(32'h9999_9999, 32'h05F5_E100));
        bus_read(BASE + 32'h8);
        check("ovf_status", rdata, pick(32'h2, 32'h0));
        bus_write(BASE, 32'd42, 4'hF);
        idle(CONV_CYCLES);
        check("conv_42", data, pick(32'h0000_0042, 32'h0000_002A));
        bus_read(BASE + 32'h8);
        check("ovf_cleared", rdata, 32'h0);

        bus_write(BASE, 32'd99_999_999, 4'hF);
        idle(CONV_CYCLES);
        check("max_no_ovf", data, pick(32'h9999_9999, 32'h05F5_E0FF));
        bus_read(BASE + 32'h8);
        check("max_status", rdata, 32'h0);

        bus_write(BASE, 32'd999, 4'hF);
        idle(10);
        bus_write(BASE, 32'd7, 4'hF);
        idle(CONV_CYCLES - 1);
        check("restart_pending", data, pick(32'h9999_9999, 32'h0000_0007));
        idle(1);
        check("restart_7", data, 32'h0000_0007);

        bus_write(BASE + 32'h4, 32'h7, 4'hF);
        bus_write(BASE, 32'd55, 4'hF);
        idle(CONV_CYCLES + 2);
        check("freeze_hold", data, 32'h0000_0007);
        bus_write(BASE + 32'h4, 32'h3, 4'hF);
        check("freeze_release", data, pick(32'h0000_0055, 32'h0000_0037));

        bus_write(BASE, 32'd1234, 4'hF);
        idle(5);
        bus_write(BASE + 32'h4, 32'h1, 4'hF);
        check("abort_raw", data, 32'h0000_04D2);
        check("abort_busy", 32'(busy), 32'h0);

        bus_rw(BASE, 32'hA5A5_A5A5);
        check("rw_prewrite", rdata, 32'h0000_04D2);
        bus_write(32'h9000_0000, 32'h1, 4'hF);
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE);
        check("oow_write_ignored", rdata, 32'hA5A5_A5A5);
        check("hex_after_abort", data, 32'hA5A5_A5A5);
        bus_read(32'h9000_0000);
        check("oow_read", rdata, 32'h0);
        bus_read(BASE + 32'hC);
        check("unmapped_read", rdata, 32'h0);
        bus_read(BASE + 32'h8);
        check("status_ro", rdata, 32'h0);

        bus_write(BASE + 32'h4, 32'h3, 4'hF);
        bus_read(BASE + 32'h4);
        check("ctrl_read", rdata, pick(32'h3, 32'h1));
        idle(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", data, 32'h0);
        check("midrst_enable_n", 32'(enable_n), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        bus_write(BASE, 32'h12, 4'hF);
        check("post_rst_hex", data, 32'h0000_0012);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
